// File: rtl/mmm_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier controller.
//   state_t    : controller FSM state (IDLE, CLR, ITER, FINAL)
//   ctr_width  : width of the iteration counter for a given operand width
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    ITER  = 2'd2,
    FINAL = 2'd3
  } state_t;

  // Counter must reach width-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int ctr_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mmm_step.sv
// One Montgomery step: rjo = rji + ai*b + qi*n, with qi chosen so rjo is even.
// Ports:
//   rji  : current accumulator value
//   ai   : current multiplier bit
//   b, n : multiplicand and modulus
//   qi   : quotient bit for this step
//   rjo  : step sum (caller stores rjo >> 1)
module mmm_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rji,
  input  logic             ai,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             qi,
  output logic [WIDTH-1:0] rjo
);

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise a latch is inferred.
  always_comb begin
    qi  = rji[0] ^ (ai & b[0]);
    // With A,B < N and N < 2^(WIDTH-2) the running sum stays below 2^WIDTH,
    // so the carry out of the top bit is always zero and need not be kept.
    rjo = rji + (ai ? b : '0) + (qi ? n : '0);
  end

endmodule

// File: rtl/shiftreg2.sv
// Accumulator register fed by the Montgomery step adder.
// Ports:
//   clk, rstb : clock, asynchronous active-low reset
//   ena       : update enable
//   clear     : active-low synchronous zero
//   load      : active-high synchronous zero
//   rjo       : step sum; the register stores rjo >> 1
//   reg_rji   : stored accumulator value
module shiftreg2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] rjo,
  output logic [WIDTH-1:0] reg_rji
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      reg_rji <= '0;
    end else if (ena) begin
      if (!clear || load) reg_rji <= '0;
      else                reg_rji <= rjo >> 1;
    end
  end

endmodule

// File: rtl/mmm_iter_ctrl.sv
// Bit-serial Montgomery multiplication controller: result = A*B*2^-WIDTH mod N.
// Drives an external shiftreg2 accumulator (rji in, rjo/acc_ena/clear/load out).
// Ports:
//   clk, rstb            : clock, asynchronous active-low reset
//   ena                  : global enable, freezes all state when low
//   start                : operation request, honoured only in IDLE
//   op_a, op_b, op_n     : operands A, B, modulus N (sampled at start)
//   rji                  : accumulator value
//   rjo                  : step sum to accumulator (0 outside ITER)
//   acc_ena, clear, load : accumulator controls
//   busy, done           : operation in progress / one-cycle completion pulse
//   result               : final product, held until the next completion
module mmm_iter_ctrl
  import mmm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_n,
  input  logic [WIDTH-1:0] rji,
  output logic [WIDTH-1:0] rjo,
  output logic             acc_ena,
  output logic             clear,
  output logic             load,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int            CW       = ctr_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_reg, n_reg;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] step_rjo;
  logic [WIDTH-1:0] final_val;
  // qi is already folded into step_rjo inside the step adder.
  logic             step_qi_unused;

  mmm_step #(.WIDTH(WIDTH)) u_step (
    .rji (rji),
    .ai  (a_sr[0]),
    .b   (b_reg),
    .n   (n_reg),
    .qi  (step_qi_unused),
    .rjo (step_rjo)
  );

  // After WIDTH steps the accumulator holds r < 2N; one subtraction suffices.
  assign final_val = (rji >= n_reg) ? (rji - n_reg) : rji;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else if (ena) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    acc_ena  = 1'b0;
    clear    = 1'b1;
    load     = 1'b0;
    rjo      = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = CLR;
      end
      CLR: begin
        acc_ena  = ena;
        clear    = 1'b0;
        load     = 1'b1;
        state_nx = ITER;
      end
      ITER: begin
        acc_ena = ena;
        rjo     = step_rjo;
        if (counter == LAST_CNT) state_nx = FINAL;
      end
      FINAL: begin
        // acc_ena stays low so rji holds the final value for the subtraction.
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_sr    <= '0;
      b_reg   <= '0;
      n_reg   <= '0;
      counter <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else if (ena) begin
      done <= (state == FINAL);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= op_a;
            b_reg   <= op_b;
            n_reg   <= op_n;
            counter <= '0;
          end
        end
        ITER: begin
          a_sr    <= a_sr >> 1;
          counter <= counter + CW'(1);
        end
        FINAL:   result <= final_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_iter_ctrl.sv
// Self-checking bench for mmm_iter_ctrl driving a shiftreg2 accumulator.
module tb_mmm_iter_ctrl;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       ena, start;
  logic [7:0] op_a, op_b, op_n, rji, rjo, result;
  logic       acc_ena, clear, load, busy, done;

  mmm_iter_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start),
    .op_a(op_a), .op_b(op_b), .op_n(op_n), .rji(rji), .rjo(rjo),
    .acc_ena(acc_ena), .clear(clear), .load(load),
    .busy(busy), .done(done), .result(result)
  );
  shiftreg2 #(.WIDTH(8)) acc8 (
    .clk(clk), .rstb(rstb), .ena(acc_ena), .clear(clear), .load(load),
    .rjo(rjo), .reg_rji(rji)
  );

  // WIDTH=4 instance
  logic       ena4 = 1'b1;
  logic       start4;
  logic [3:0] op_a4, op_b4, op_n4, rji4, rjo4, result4;
  logic       acc_ena4, clear4, load4, busy4, done4;

  mmm_iter_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rstb(rstb), .ena(ena4), .start(start4),
    .op_a(op_a4), .op_b(op_b4), .op_n(op_n4), .rji(rji4), .rjo(rjo4),
    .acc_ena(acc_ena4), .clear(clear4), .load(load4),
    .busy(busy4), .done(done4), .result(result4)
  );
  shiftreg2 #(.WIDTH(4)) acc4 (
    .clk(clk), .rstb(rstb), .ena(acc_ena4), .clear(clear4), .load(load4),
    .rjo(rjo4), .reg_rji(rji4)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] last_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Montgomery product from its definition: the x in [0,N) with x*2^w == a*b (mod N).
  function automatic int mont_ref(input int a, input int b, input int n, input int w);
    int p, r;
    p = (a * b) % n;
    r = (1 << w) % n;
    for (int x = 0; x < n; x++)
      if ((x * r) % n == p) return x;
    return -1;
  endfunction

  // Runs one WIDTH=8 operation starting in the current cycle (cycle 0) and
  // returns in the cycle where done is observed. freeze>0 drops ena for three
  // cycles starting at that cycle; spam keeps start high while busy.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                     input int freeze, input bit spam, input string tag);
    int         cyc;
    logic [7:0] snap, expv;
    expv  = 8'(mont_ref(a, b, n, 8));
    op_a  = a;
    op_b  = b;
    op_n  = n;
    start = 1'b1;
    step();
    cyc = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_res_held"}, 32'(result), 32'(last_res));
    start = spam;
    op_a  = 8'($urandom);
    op_b  = 8'($urandom);
    op_n  = 8'($urandom);
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == freeze) begin
        ena  = 1'b0;
        snap = rji;
        repeat (3) begin
          step();
          cyc++;
          check({tag, "_frz_rji"}, 32'(rji), 32'(snap));
          check({tag, "_frz_accena"}, 32'(acc_ena), 32'd0);
          check({tag, "_frz_done"}, 32'(done), 32'd0);
        end
        ena = 1'b1;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(11 + ((freeze > 0) ? 3 : 0)));
    check({tag, "_result"}, 32'(result), 32'(expv));
    last_res = expv;
  endtask

  initial begin
    int cyc, dones;
    logic [7:0] rn, ra, rb;
    ena = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_n = '0;
    start4 = 1'b0; op_a4 = '0; op_b4 = '0; op_n4 = '0;
    last_res = '0;

    // Reset values
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_accena", 32'(acc_ena), 32'd0);
    check("rst_clear", 32'(clear), 32'd1);
    check("rst_load", 32'(load), 32'd0);
    check("rst_rjo", 32'(rjo), 32'd0);
    rstb = 1'b1;
    step();
    check("idle_accena", 32'(acc_ena), 32'd0);

    // Basic, then back-to-back with start asserted in each done cycle
    op8(8'd5, 8'd7, 8'd13, 0, 1'b0, "basic");
    op8(8'd12, 8'd12, 8'd13, 0, 1'b0, "b2b1");
    op8(8'd0, 8'd9, 8'd13, 0, 1'b0, "b2b2");
    step();
    check("b2b_idle_done", 32'(done), 32'd0);
    check("b2b_idle_busy", 32'(busy), 32'd0);

    // start held high throughout: exactly one completion
    op8(8'd5, 8'd7, 8'd13, 0, 1'b1, "spam");
    dones = 0;
    repeat (4) begin
      step();
      if (done === 1'b1) dones++;
    end
    check("spam_extra_done", 32'(dones), 32'd0);
    check("spam_idle_busy", 32'(busy), 32'd0);

    // ena low for three cycles in ITER
    op8(8'd5, 8'd7, 8'd13, 5, 1'b0, "freeze");
    step();

    // WIDTH=4: N=3, A=B=2 -> 1 at cycle 7, rjo even in every ITER cycle
    op_a4 = 4'd2; op_b4 = 4'd2; op_n4 = 4'd3; start4 = 1'b1;
    step();
    cyc = 1;
    start4 = 1'b0;
    while (done4 !== 1'b1 && cyc < 20) begin
      if (cyc >= 2 && cyc <= 5) begin
        check("w4_rjo_even", 32'(rjo4[0]), 32'd0);
        check("w4_iter_accena", 32'(acc_ena4), 32'd1);
      end
      if (cyc == 6) check("w4_final_accena", 32'(acc_ena4), 32'd0);
      step();
      cyc++;
    end
    check("w4_latency", 32'(cyc), 32'd7);
    check("w4_result", 32'(result4), 32'(mont_ref(2, 2, 3, 4)));
    check("w4_idle_accena", 32'(acc_ena4), 32'd0);

    // Asynchronous reset in the middle of ITER
    op_a = 8'd5; op_b = 8'd7; op_n = 8'd13; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rstb = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_accena", 32'(acc_ena), 32'd0);
    check("mid_rst_rjo", 32'(rjo), 32'd0);
    check("mid_rst_acc", 32'(rji), 32'd0);
    last_res = '0;
    #2;
    rstb = 1'b1;
    dones = 0;
    repeat (12) begin
      step();
      if (done === 1'b1) dones++;
    end
    check("mid_rst_no_done", 32'(dones), 32'd0);
    op8(8'd5, 8'd7, 8'd13, 0, 1'b0, "post_rst");

    // Randomized legal operands against the reference model
    for (int i = 0; i < 8; i++) begin
      rn = 8'($urandom_range(0, 31) * 2 + 1);
      ra = 8'($urandom_range(0, int'(rn) - 1));
      rb = 8'($urandom_range(0, int'(rn) - 1));
      op8(ra, rb, rn, 0, 1'b0, "rand");
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
